// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing scheduler: op codes, FSM encoding and op legality check.
package alu_pkg;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_MUL  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [CTRL_W-1:0] ctrl);
        logic legal;
        legal = 1'b0;
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SUB,
            ALU_SRL, ALU_MUL, ALU_XOR, ALU_SLTU: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request at or after ptr.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic              found;
    logic [PTR_W-1:0]  idx;
    int unsigned       pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // Walk the requesters starting from ptr, wrapping modulo N.
            pos = (32'(ptr) + i) % N;
            idx = PTR_W'(pos);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one external combinational ALU among NUM_REQ requesters with round-robin issue.
// Optional feature: define ALU_SCHED_B2B_EN to issue the next op in the response-accept cycle.
module alu_share_sched #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = alu_pkg::CTRL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_in1,
    input  logic [NUM_REQ*DATA_W-1:0]  req_in2,
    input  logic [NUM_REQ*CTRL_W-1:0]  req_ctrl,
    output logic [DATA_W-1:0]          alu_in1,
    output logic [DATA_W-1:0]          alu_in2,
    output logic [CTRL_W-1:0]          alu_ctrl,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_illegal
);

    import alu_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0]   alu_in2_q, alu_in2_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_illegal_q, rsp_illegal_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic [DATA_W-1:0]   sel_in1;
    logic [DATA_W-1:0]   sel_in2;
    logic [CTRL_W-1:0]   sel_ctrl;
    logic                issue;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Encode the one-hot grant and select the winner's payload.
    always_comb begin
        gnt_idx  = '0;
        sel_in1  = '0;
        sel_in2  = '0;
        sel_ctrl = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = ID_W'(i);
                sel_in1  = req_in1[i*DATA_W +: DATA_W];
                sel_in2  = req_in2[i*DATA_W +: DATA_W];
                sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        alu_in1_d     = alu_in1_q;
        alu_in2_d     = alu_in2_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        req_ready     = '0;
        issue         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = gnt;
                issue     = |gnt;
            end
            S_EXEC: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
                if (is_legal_op(alu_ctrl_q)) begin
                    rsp_result_d  = alu_result;
                    rsp_zero_d    = alu_zero;
                    rsp_illegal_d = 1'b0;
                end else begin
                    rsp_result_d  = '0;
                    rsp_zero_d    = 1'b1;
                    rsp_illegal_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_illegal_d = 1'b0;
                    state_d       = S_IDLE;
`ifdef ALU_SCHED_B2B_EN
                    req_ready = gnt;
                    issue     = |gnt;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            alu_in1_d  = sel_in1;
            alu_in2_d  = sel_in2;
            alu_ctrl_d = sel_ctrl;
            rsp_id_d   = gnt_idx;
            ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state_d    = S_EXEC;
        end

        // Nothing may be accepted while reset is held.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_ctrl_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            alu_in1_q     <= alu_in1_d;
            alu_in2_q     <= alu_in2_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
